// File: rtl/dcache_miss_ctrl.sv
// Data-cache miss controller: hit path, write-back and refill sequencing.
// Define DCACHE_PERF_CNT_EN to add hit/miss/write-back counters.
module dcache_miss_ctrl #(
   parameter int IDX_W  = 4,
   parameter int LINE_W = 256
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              cpu_req_i,
   input  logic              cpu_wr_i,
   input  logic [31:0]       cpu_addr_i,
   input  logic [31:0]       cpu_data_i,
   output logic [31:0]       cpu_data_o,
   output logic              cpu_stall_o,
   output logic              sram_en_o,
   output logic              sram_wr_o,
   output logic [IDX_W-1:0]  sram_idx_o,
   output logic [24:0]       sram_tag_o,
   output logic [LINE_W-1:0] sram_data_o,
   input  logic              sram_hit_i,
   input  logic [24:0]       sram_tag_i,
   input  logic [LINE_W-1:0] sram_data_i,
   output logic              mem_req_o,
   output logic              mem_wr_o,
   output logic [31:0]       mem_addr_o,
   output logic [LINE_W-1:0] mem_data_o,
   input  logic              mem_ack_i,
   input  logic [LINE_W-1:0] mem_data_i
`ifdef DCACHE_PERF_CNT_EN
   ,
   output logic [31:0]       hit_cnt_o,
   output logic [31:0]       miss_cnt_o,
   output logic [31:0]       wb_cnt_o
`endif
);

   localparam int TAG_W = 32 - IDX_W - 5;

   typedef enum logic [2:0] {
      S_IDLE, S_MISS, S_WB_REQ, S_RF_REQ, S_FILL
   } state_t;

   state_t             state;
   logic               q_wr;
   logic [TAG_W-1:0]   q_tag;
   logic [IDX_W-1:0]   q_idx;
   logic [2:0]         q_word;
   logic [31:0]        q_data;
   logic [24:0]        v_tag;
   logic [LINE_W-1:0]  line_q;
   logic               lookup;
   logic               unused;

   assign unused = ^cpu_addr_i[1:0];
   assign lookup = !rst_i && state == S_IDLE && cpu_req_i;

   function automatic logic [LINE_W-1:0] merge_word(
      input logic [LINE_W-1:0] line,
      input logic [2:0]        sel,
      input logic [31:0]       w
   );
      logic [LINE_W-1:0] m;
      m = line;
      m[{sel, 5'b0} +: 32] = w;
      return m;
   endfunction

   // Address path kept free of sram_hit_i so the SRAM lookup has no loop.
   always_comb begin
      sram_en_o  = 1'b0;
      sram_idx_o = '0;
      sram_tag_o = '0;
      if (!rst_i) begin
         if (state == S_FILL) begin
            sram_en_o  = 1'b1;
            sram_idx_o = q_idx;
            sram_tag_o = {1'b1, q_wr, q_tag};
         end else if (lookup) begin
            sram_en_o  = 1'b1;
            sram_idx_o = cpu_addr_i[8:5];
            sram_tag_o = {1'b1, cpu_wr_i, cpu_addr_i[31:9]};
         end
      end
   end

   always_comb begin
      sram_wr_o   = 1'b0;
      sram_data_o = '0;
      cpu_data_o  = '0;
      cpu_stall_o = 1'b0;
      if (!rst_i) begin
         if (state == S_FILL) begin
            sram_wr_o   = 1'b1;
            sram_data_o = line_q;
         end else if (lookup && sram_hit_i) begin
            if (cpu_wr_i) begin
               sram_wr_o   = 1'b1;
               sram_data_o = merge_word(sram_data_i, cpu_addr_i[4:2],
                                        cpu_data_i);
            end else begin
               cpu_data_o = sram_data_i[{cpu_addr_i[4:2], 5'b0} +: 32];
            end
         end
         cpu_stall_o = (state != S_IDLE) || (lookup && !sram_hit_i);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state      <= S_IDLE;
         mem_req_o  <= 1'b0;
         mem_wr_o   <= 1'b0;
         mem_addr_o <= '0;
         mem_data_o <= '0;
         q_wr       <= 1'b0;
         q_tag      <= '0;
         q_idx      <= '0;
         q_word     <= '0;
         q_data     <= '0;
         v_tag      <= '0;
         line_q     <= '0;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (lookup && !sram_hit_i) begin
                  q_wr   <= cpu_wr_i;
                  q_tag  <= cpu_addr_i[31:9];
                  q_idx  <= cpu_addr_i[8:5];
                  q_word <= cpu_addr_i[4:2];
                  q_data <= cpu_data_i;
                  v_tag  <= sram_tag_i;
                  line_q <= sram_data_i;
                  state  <= S_MISS;
               end
            end
            S_MISS: begin
               mem_req_o <= 1'b1;
               if (v_tag[24] && v_tag[23]) begin
                  mem_wr_o   <= 1'b1;
                  mem_addr_o <= {v_tag[TAG_W-1:0], q_idx, 5'b0};
                  mem_data_o <= line_q;
                  state      <= S_WB_REQ;
               end else begin
                  mem_wr_o   <= 1'b0;
                  mem_addr_o <= {q_tag, q_idx, 5'b0};
                  mem_data_o <= '0;
                  state      <= S_RF_REQ;
               end
            end
            S_WB_REQ: begin
               if (mem_ack_i) begin
                  mem_wr_o   <= 1'b0;
                  mem_addr_o <= {q_tag, q_idx, 5'b0};
                  mem_data_o <= '0;
                  state      <= S_RF_REQ;
               end
            end
            S_RF_REQ: begin
               if (mem_ack_i) begin
                  line_q     <= q_wr ? merge_word(mem_data_i, q_word, q_data)
                                     : mem_data_i;
                  mem_req_o  <= 1'b0;
                  mem_addr_o <= '0;
                  state      <= S_FILL;
               end
            end
            S_FILL:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

`ifdef DCACHE_PERF_CNT_EN
   logic relook;

   // The lookup right after a fill is the retried miss, not a new hit.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         hit_cnt_o  <= '0;
         miss_cnt_o <= '0;
         wb_cnt_o   <= '0;
         relook     <= 1'b0;
      end else begin
         relook <= (state == S_FILL);
         if (lookup && sram_hit_i && !relook && hit_cnt_o != '1)
            hit_cnt_o <= hit_cnt_o + 32'd1;
         if (lookup && !sram_hit_i && miss_cnt_o != '1)
            miss_cnt_o <= miss_cnt_o + 32'd1;
         if (state == S_WB_REQ && mem_ack_i && wb_cnt_o != '1)
            wb_cnt_o <= wb_cnt_o + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_dcache_miss_ctrl.sv
// Directed bench for dcache_miss_ctrl with a 2-way SRAM model
// and a latency-programmable memory model.
module tb_dcache_miss_ctrl;

   logic         clk = 1'b0;
   logic         rst_i;
   logic         cpu_req_i, cpu_wr_i;
   logic [31:0]  cpu_addr_i, cpu_data_i, cpu_data_o;
   logic         cpu_stall_o;
   logic         sram_en_o, sram_wr_o;
   logic [3:0]   sram_idx_o;
   logic [24:0]  sram_tag_o, sram_tag_i;
   logic [255:0] sram_data_o, sram_data_i;
   logic         sram_hit_i;
   logic         mem_req_o, mem_wr_o;
   logic [31:0]  mem_addr_o;
   logic [255:0] mem_data_o;
   logic         mem_ack_i = 1'b0;
   logic [255:0] mem_data_i = '0;
`ifdef DCACHE_PERF_CNT_EN
   logic [31:0]  hit_cnt_o, miss_cnt_o, wb_cnt_o;
`endif

   always #5 clk = ~clk;

   dcache_miss_ctrl dut (
      .clk_i(clk), .rst_i(rst_i),
      .cpu_req_i(cpu_req_i), .cpu_wr_i(cpu_wr_i),
      .cpu_addr_i(cpu_addr_i), .cpu_data_i(cpu_data_i),
      .cpu_data_o(cpu_data_o), .cpu_stall_o(cpu_stall_o),
      .sram_en_o(sram_en_o), .sram_wr_o(sram_wr_o),
      .sram_idx_o(sram_idx_o), .sram_tag_o(sram_tag_o),
      .sram_data_o(sram_data_o), .sram_hit_i(sram_hit_i),
      .sram_tag_i(sram_tag_i), .sram_data_i(sram_data_i),
      .mem_req_o(mem_req_o), .mem_wr_o(mem_wr_o),
      .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
      .mem_ack_i(mem_ack_i), .mem_data_i(mem_data_i)
`ifdef DCACHE_PERF_CNT_EN
      ,
      .hit_cnt_o(hit_cnt_o), .miss_cnt_o(miss_cnt_o),
      .wb_cnt_o(wb_cnt_o)
`endif
   );

   // SRAM model: 16 sets x 2 ways, LRU victim returned on miss.
   logic [24:0]  tg [16][2];
   logic [255:0] dt [16][2];
   logic         lru [16];
   logic         h0, h1;
   int           sram_wcnt = 0;
   logic [24:0]  lw_tag = '0;
   logic [255:0] lw_data = '0;

   always_comb begin
      h0 = tg[sram_idx_o][0][24] &&
           tg[sram_idx_o][0][22:0] == sram_tag_o[22:0];
      h1 = tg[sram_idx_o][1][24] &&
           tg[sram_idx_o][1][22:0] == sram_tag_o[22:0];
      sram_hit_i = sram_en_o && (h0 || h1);
      if (h1) begin
         sram_tag_i  = tg[sram_idx_o][1];
         sram_data_i = dt[sram_idx_o][1];
      end else if (h0) begin
         sram_tag_i  = tg[sram_idx_o][0];
         sram_data_i = dt[sram_idx_o][0];
      end else begin
         sram_tag_i  = tg[sram_idx_o][lru[sram_idx_o]];
         sram_data_i = dt[sram_idx_o][lru[sram_idx_o]];
      end
   end

   always @(posedge clk) begin
      int w;
      if (sram_en_o) begin
         w = h1 ? 1 : (h0 ? 0 : int'(lru[sram_idx_o]));
         if (sram_wr_o) begin
            tg[sram_idx_o][w] <= sram_tag_o;
            dt[sram_idx_o][w] <= sram_data_o;
            lw_tag    <= sram_tag_o;
            lw_data   <= sram_data_o;
            sram_wcnt <= sram_wcnt + 1;
         end
         if (h0 || h1 || sram_wr_o) lru[sram_idx_o] <= (w == 0);
      end
   end

   // Memory model: ack lat cycles after req rise, line content by address.
   logic [255:0] mem [logic [31:0]];
   int           lat = 0;
   int           mcnt = 0;
   int           wb_cnt = 0;
   logic [31:0]  wb_addr = '0;
   logic [255:0] wb_data = '0;

   function automatic logic [255:0] dflt(input logic [31:0] a);
      logic [255:0] l;
      for (int k = 0; k < 8; k++) l[32*k +: 32] = a + 32'(k);
      return l;
   endfunction

   always @(negedge clk) begin
      if (mem_ack_i) begin
         mem_ack_i = 1'b0;
         mcnt = 0;
      end
      if (mem_req_o) begin
         if (mcnt == lat) begin
            mem_ack_i = 1'b1;
            if (mem_wr_o) begin
               mem[mem_addr_o] = mem_data_o;
               wb_addr = mem_addr_o;
               wb_data = mem_data_o;
               wb_cnt++;
            end else begin
               mem_data_i = mem.exists(mem_addr_o) ? mem[mem_addr_o]
                                                   : dflt(mem_addr_o);
            end
         end else begin
            mcnt++;
         end
      end else begin
         mcnt = 0;
      end
   end

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [255:0] obs,
                        input logic [255:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   logic         ls_wr;
   logic [24:0]  ls_tag;
   logic [255:0] ls_data;

   task automatic do_acc(input logic wr, input logic [31:0] a,
                         input logic [31:0] d, output int st,
                         output logic [31:0] rd);
      cpu_req_i  = 1'b1;
      cpu_wr_i   = wr;
      cpu_addr_i = a;
      cpu_data_i = d;
      st = 0;
      @(negedge clk);
      while (cpu_stall_o && st < 100) begin
         st++;
         @(negedge clk);
      end
      rd      = cpu_data_o;
      ls_wr   = sram_wr_o;
      ls_tag  = sram_tag_o;
      ls_data = sram_data_o;
      @(posedge clk);
      #1;
      cpu_req_i = 1'b0;
      cpu_wr_i  = 1'b0;
   endtask

   initial begin
      int          st, wc0;
      logic [31:0] rd;
      logic [255:0] t;
      for (int s = 0; s < 16; s++) begin
         lru[s] = 1'b0;
         for (int w = 0; w < 2; w++) begin
            tg[s][w] = '0;
            dt[s][w] = '0;
         end
      end
      t = dflt(32'h400);
      t[63:32] = 32'hDEADBEEF;
      mem[32'h400] = t;
      rst_i = 1'b1;
      cpu_req_i = 1'b0; cpu_wr_i = 1'b0;
      cpu_addr_i = '0; cpu_data_i = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_stall", cpu_stall_o, 0);
      check("rst_mreq", mem_req_o, 0);
      check("rst_sen", sram_en_o, 0);
      check("rst_cdata", cpu_data_o, 0);
      check("rst_maddr", mem_addr_o, 0);
      @(posedge clk); #1;
      rst_i = 1'b0;
      @(negedge clk);
      check("idle_sen", sram_en_o, 0);
      @(posedge clk); #1;

      lat = 3;
      do_acc(1'b0, 32'h404, '0, st, rd);
      check("ld404_stall", st, 7);
      check("ld404_data", rd, 32'hDEADBEEF);
      check("ld404_ftag", lw_tag, 25'h1000002);

      do_acc(1'b1, 32'h408, 32'h12345678, st, rd);
      check("st408_stall", st, 0);
      check("st408_wr", ls_wr, 1);
      check("st408_tag", ls_tag, 25'h1800002);
      check("st408_w2", ls_data[95:64], 32'h12345678);
      check("st408_w1", ls_data[63:32], 32'hDEADBEEF);

      do_acc(1'b0, 32'h408, '0, st, rd);
      check("ld408_stall", st, 0);
      check("ld408_data", rd, 32'h12345678);

      do_acc(1'b0, 32'h600, '0, st, rd);
      check("ld600_stall", st, 7);
      check("ld600_data", rd, 32'h600);

      do_acc(1'b0, 32'h80C, '0, st, rd);
      check("ld80c_stall", st, 11);
      check("ld80c_data", rd, 32'h803);
      check("wb_cnt", wb_cnt, 1);
      check("wb_addr", wb_addr, 32'h400);
      check("wb_w2", wb_data[95:64], 32'h12345678);
      check("wb_w1", wb_data[63:32], 32'hDEADBEEF);

      lat = 0;
      do_acc(1'b0, 32'h24, '0, st, rd);
      check("ld24_stall", st, 4);
      check("ld24_data", rd, 32'h21);

      do_acc(1'b1, 32'h48, 32'hCAFEF00D, st, rd);
      check("st48_stall", st, 4);
      check("st48_tag", lw_tag, 25'h1800000);
      check("st48_w2", lw_data[95:64], 32'hCAFEF00D);
      check("st48_w0", lw_data[31:0], 32'h40);

`ifdef DCACHE_PERF_CNT_EN
      check("perf_hit", hit_cnt_o, 2);
      check("perf_miss", miss_cnt_o, 5);
      check("perf_wb", wb_cnt_o, 1);
`endif

      lat = 5;
      cpu_req_i = 1'b1; cpu_wr_i = 1'b0;
      cpu_addr_i = 32'h64; cpu_data_i = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rf_mreq", mem_req_o, 1);
      wc0 = sram_wcnt;
      rst_i = 1'b1;
      @(negedge clk);
      check("rrst_mreq", mem_req_o, 0);
      check("rrst_sen", sram_en_o, 0);
      check("rrst_stall", cpu_stall_o, 0);
      @(posedge clk); #1;
      rst_i = 1'b0;
      cpu_req_i = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rrst_nowr", sram_wcnt, wc0);
      lat = 0;
      do_acc(1'b0, 32'h64, '0, st, rd);
      check("ld64_stall", st, 4);
      check("ld64_data", rd, 32'h61);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/dcache_miss_ctrl.md
# dcache_miss_ctrl

Data-cache controller between the CPU memory stage and the 2-way set-associative `dcache_sram` (16 sets × 2 ways, 256-bit lines, 25-bit tag word {valid, dirty, tag[22:0]}). It decodes 32-bit CPU addresses, serves read and write hits with no stall, merges 32-bit store words into lines, and on a miss runs a write-back/refill sequence against main memory through a req/ack handshake. It is the stage directly upstream of `dcache_sram` and owns the only path from the cache to memory.

## Interface
- `IDX_W`, 4, set-index width (16 sets); fixed geometry, not for override.
- `LINE_W`, 256, line width in bits (8 words).
- `clk_i` in 1: clock, all state on rising edge.
- `rst_i` in 1: reset, synchronous, active-high.
- `cpu_req_i` in 1: CPU access valid. `cpu_wr_i` in 1: 1 = store. `cpu_addr_i` in 32: byte address. `cpu_data_i` in 32: store data.
- `cpu_data_o` out 32: load data. `cpu_stall_o` out 1: CPU must hold its request.
- `sram_en_o` out 1, `sram_wr_o` out 1, `sram_idx_o` out 4, `sram_tag_o` out 25, `sram_data_o` out 256: SRAM request.
- `sram_hit_i` in 1, `sram_tag_i` in 25, `sram_data_i` in 256: SRAM response (hit line on hit; LRU victim line on miss).
- `mem_req_o` out 1, `mem_wr_o` out 1, `mem_addr_o` out 32, `mem_data_o` out 256: memory request.
- `mem_ack_i` in 1, `mem_data_i` in 256: memory response.

## Operation
- Address split: tag = `cpu_addr_i[31:9]`, index = `[8:5]`, word = `[4:2]`; word k occupies line bits [32k+31:32k].
- States: IDLE, MISS, WB_REQ, RF_REQ, FILL.
- IDLE, `cpu_req_i`=1: `sram_en_o`=1, index/tag driven combinationally.
  - Read hit: `cpu_data_o` = selected word of `sram_data_i`; stall 0.
  - Write hit: `sram_wr_o`=1, `sram_data_o` = `sram_data_i` with word replaced, `sram_tag_o` = {1,1,tag}; stall 0.
  - Miss: stall 1, capture victim tag/data and request; -> MISS.
- MISS: victim valid & dirty -> WB_REQ; else -> RF_REQ.
- WB_REQ: `mem_req_o`=1, `mem_wr_o`=1, `mem_addr_o` = {victim tag, index, 5'b0}, `mem_data_o` = victim data; on `mem_ack_i` -> RF_REQ.
- RF_REQ: `mem_req_o`=1, `mem_wr_o`=0, `mem_addr_o` = {req tag, index, 5'b0}; on `mem_ack_i` capture `mem_data_i` -> FILL.
- FILL: `sram_en_o`=`sram_wr_o`=1, tag {1, cpu_wr, tag}, data = refill line with store word merged if store; -> IDLE, where the held request re-looks up and hits.
- `cpu_stall_o` = 1 in every non-IDLE state, and in IDLE on a miss.

## Timing
- Reset values: state IDLE; `mem_req_o`, `mem_wr_o`, `sram_en_o`, `sram_wr_o`, `cpu_stall_o` = 0; `mem_addr_o`, `mem_data_o`, `sram_*` buses, `cpu_data_o` = 0.
- Hit: zero stall cycles.
- Clean miss, memory ack L cycles after req rise (L≥0 same-cycle ack allowed): stall = 1 (IDLE) + 1 (MISS) + L+1 (RF_REQ) + 1 (FILL) cycles, released in re-lookup IDLE cycle.
- Dirty miss adds L+1 cycles for WB_REQ.
- `mem_req_o` held high with stable addr/data until the cycle `mem_ack_i`=1; deasserted or re-targeted on the next edge. `mem_ack_i` while `mem_req_o`=0 is ignored.
- CPU request changes while stalled are ignored; captured request is used.
- Reset mid-miss: next edge returns to IDLE with all outputs at reset values; outstanding memory transaction abandoned, no SRAM write.
- `cpu_req_i`=0 in IDLE: no SRAM enable, no state change.

## Configuration
- `DCACHE_PERF_CNT_EN` defined: adds outputs `hit_cnt_o`, `miss_cnt_o`, `wb_cnt_o` (32 bits each), reset to 0, incremented on first-lookup hit, on miss entry, on WB_REQ ack; saturate at 0xFFFFFFFF. Re-lookup after FILL not counted as hit.
- Undefined: ports and counters absent; functional behaviour identical.

## Test plan
- Reset, load 0x0000_0404 with memory ack L=3, line word1 = 0xDEADBEEF -> stall 7 cycles, `cpu_data_o`=0xDEADBEEF, SRAM tag {1,0,tag}.
- Store 0x1234_5678 to 0x0000_0408 (hit) -> no stall, `sram_wr_o`=1, line word2 = 0x12345678, dirty=1.
- Fill both ways of set 0 (one dirty), access third tag -> WB_REQ write of dirty victim at {old tag,0,00000}, then refill; stall 7+4 cycles at L=3.
- Memory ack same cycle as req (L=0) -> clean-miss stall exactly 4 cycles.
- Assert `rst_i` during RF_REQ -> next cycle `mem_req_o`=0, state IDLE, no SRAM write.
- With `DCACHE_PERF_CNT_EN`: 2 misses (1 dirty), 3 hits -> `hit_cnt_o`=3, `miss_cnt_o`=2, `wb_cnt_o`=1.
